// File: rtl/ping_pkg.sv
// ping_pkg: shared types and default timing for the PING sensor scheduler.
//   ping_state_t       - scheduler FSM states
//   PING_CLK_MHZ       - default clock cycles per microsecond
//   PING_T_*_US        - default phase lengths in microseconds
//   idx_w()            - index width for an N-wide requester vector (min 1)
package ping_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HOLD,
    S_WAIT_RISE,
    S_MEASURE,
    S_DELAY
  } ping_state_t;

  localparam int PING_CLK_MHZ       = 50;
  localparam int PING_T_START_US    = 5;
  localparam int PING_T_HOLD_US     = 750;
  localparam int PING_T_DELAY_US    = 200;
  localparam int PING_T_ECHO_MAX_US = 18500;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ping_sched_if.sv
// ping_sched_if: requester handshake, result bus and sensor pin signals of
// the PING scheduler.
//   master - requester/pin side: drives req, pulsein
//   slave  - scheduler side: drives grant, pin controls and the result
interface ping_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  import ping_pkg::*;
  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            pulsein;
  logic            pulseout;
  logic            pulseen;
  logic            busy;
  logic            done;
  logic [IW-1:0]   done_id;
  logic [W-1:0]    echo_us;
  logic            timeout;

  modport master (
    output req, pulsein,
    input  grant, pulseout, pulseen, busy, done, done_id, echo_us, timeout
  );

  modport slave (
    input  req, pulsein,
    output grant, pulseout, pulseen, busy, done, done_id, echo_us, timeout
  );
endinterface

// File: rtl/ping_rr_arb.sv
// ping_rr_arb: round-robin arbiter over NREQ level requests.
//   clk, reset - clock, synchronous active-high reset (pointer -> 0)
//   req        - request vector
//   adv        - when high and a request wins, pointer moves past the winner
//   gnt/idx    - one-hot winner and its index (combinational)
//   valid      - some request is high
module ping_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);
  logic [IW-1:0] ptr_q, ptr_d;

  // First high request at or after the pointer, wrapping at NREQ.
  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  always_comb begin
    int nx;
    ptr_d = ptr_q;
    nx    = int'(idx) + 1;
    if (nx >= NREQ) nx = 0;
    if (adv && valid) ptr_d = IW'(nx);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/ping_sched.sv
// ping_sched: shares one PING ultrasonic sensor among NREQ requesters and
// runs the start / hold-off / echo-wait / measure / re-arm sequence, timing
// every phase from an internal microsecond prescaler.
//   clk, reset - clock, synchronous active-high reset
//   bus.req/grant           - level requests, one-hot owner of current ping
//   bus.pulsein             - echo line from the pin
//   bus.pulseout/pulseen    - pin drive value / output enable
//   bus.busy                - not IDLE
//   bus.done/done_id/echo_us/timeout - one-cycle result strobe + held result
// Macro PING_SCHED_SYNC_EN: when defined, pulsein goes through a 2-flop
// synchronizer; otherwise it is used directly.
module ping_sched
  import ping_pkg::*;
#(
  parameter int CLK_MHZ       = PING_CLK_MHZ,
  parameter int NREQ          = 4,
  parameter int W             = 16,
  parameter int T_START_US    = PING_T_START_US,
  parameter int T_HOLD_US     = PING_T_HOLD_US,
  parameter int T_ECHO_MAX_US = PING_T_ECHO_MAX_US,
  parameter int T_DELAY_US    = PING_T_DELAY_US
) (
  input  logic         clk,
  input  logic         reset,
  ping_sched_if.slave  bus
);
  localparam int IW = idx_w(NREQ);
  localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_MHZ - 1);
  localparam logic [W-1:0]  START_W    = W'(T_START_US);
  localparam logic [W-1:0]  HOLD_W     = W'(T_HOLD_US);
  localparam logic [W-1:0]  EMAX_W     = W'(T_ECHO_MAX_US);
  localparam logic [W-1:0]  DELAY_W    = W'(T_DELAY_US);

  ping_state_t     state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [W-1:0]    us_q, us_d, us_nxt;
  logic            tick;
  logic [NREQ-1:0] own_q, own_d;
  logic [IW-1:0]   id_q, id_d;
  logic            done_q, done_d;
  logic            to_q, to_d;
  logic [W-1:0]    echo_q, echo_d;
  logic [IW-1:0]   did_q, did_d;
  logic            echo;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;

`ifdef PING_SCHED_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], bus.pulsein};
  end
  assign echo = sync_q[1];
`else
  assign echo = bus.pulsein;
`endif

  ping_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req),
    .adv   (state_q == S_IDLE),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_vld)
  );

  // Thresholds compare against the count including this cycle's tick, so a
  // phase of T us lasts exactly T*CLK_MHZ cycles and a measured echo of H
  // cycles reports floor(H/CLK_MHZ).
  assign tick   = (presc_q == PRESC_LAST);
  assign us_nxt = (tick && us_q != '1) ? us_q + 1'b1 : us_q;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    id_d    = id_q;
    done_d  = 1'b0;
    to_d    = to_q;
    echo_d  = echo_q;
    did_d   = did_q;
    unique case (state_q)
      S_IDLE: if (arb_vld) begin
        state_d = S_START;
        own_d   = arb_gnt;
        id_d    = arb_idx;
      end
      S_START:     if (us_nxt >= START_W) state_d = S_HOLD;
      S_HOLD:      if (us_nxt >= HOLD_W)  state_d = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (echo) state_d = S_MEASURE;
        else if (us_nxt >= EMAX_W) begin
          state_d = S_DELAY;
          own_d   = '0;
          done_d  = 1'b1;
          to_d    = 1'b1;
          echo_d  = '0;
          did_d   = id_q;
        end
      end
      S_MEASURE: begin
        if (!echo || us_nxt >= EMAX_W) begin
          state_d = S_DELAY;
          own_d   = '0;
          done_d  = 1'b1;
          to_d    = echo;
          echo_d  = echo ? EMAX_W : us_nxt;
          did_d   = id_q;
        end
      end
      S_DELAY: if (us_nxt >= DELAY_W && !echo) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Phase timers restart on every state entry.
    if (state_d != state_q) begin
      presc_d = '0;
      us_d    = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      us_d    = us_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      us_q    <= '0;
      own_q   <= '0;
      id_q    <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      echo_q  <= '0;
      did_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      us_q    <= us_d;
      own_q   <= own_d;
      id_q    <= id_d;
      done_q  <= done_d;
      to_q    <= to_d;
      echo_q  <= echo_d;
      did_q   <= did_d;
    end
  end

  // Pin is released once the sensor owns it (echo wait, measure, re-arm).
  assign bus.grant    = own_q;
  assign bus.pulseout = (state_q == S_START);
  assign bus.pulseen  = (state_q == S_IDLE) || (state_q == S_START) ||
                        (state_q == S_HOLD);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.done_id  = did_q;
  assign bus.echo_us  = echo_q;
  assign bus.timeout  = to_q;
endmodule

// File: tb/tb_ping_sched.sv
module tb_ping_sched;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   n;
  int   dn;

  always #5 clk = ~clk;

  ping_sched_if #(.NREQ(4), .W(16)) ifA ();
  ping_sched_if #(.NREQ(4), .W(16)) ifB ();

  ping_sched #(.CLK_MHZ(2), .NREQ(4), .W(16)) dutA (
    .clk(clk), .reset(reset), .bus(ifA)
  );
  ping_sched #(.CLK_MHZ(2), .NREQ(4), .W(16), .T_ECHO_MAX_US(50)) dutB (
    .clk(clk), .reset(reset), .bus(ifB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ifA.req = '0; ifA.pulsein = 1'b0;
    ifB.req = '0; ifB.pulsein = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_pulseout", 32'(ifA.pulseout), 0);
    chk("rst_pulseen",  32'(ifA.pulseen), 1);
    chk("rst_grant",    32'(ifA.grant), 0);
    chk("rst_busy",     32'(ifA.busy), 0);
    chk("rst_done",     32'(ifA.done), 0);
    chk("rst_echo",     32'(ifA.echo_us), 0);
    chk("rst_timeout",  32'(ifA.timeout), 0);
    chk("rst_done_id",  32'(ifA.done_id), 0);

    // single ping, requester 1, 200-cycle echo
    reset = 1'b0;
    ifA.req = 4'b0010;
    @(negedge clk);
    chk("p1_grant", 32'(ifA.grant), 32'b0010);
    chk("p1_busy",  32'(ifA.busy), 1);
    ifA.req = '0;
    n = 0;
    while (ifA.pulseout && n < 100) begin n++; @(negedge clk); end
    chk("p1_start_len", 32'(n), 10);
    n = 0;
    while (ifA.pulseen && n < 3000) begin n++; @(negedge clk); end
    chk("p1_hold_len", 32'(n), 1500);
    chk("p1_grant_held", 32'(ifA.grant), 32'b0010);
    ifA.pulsein = 1'b1;
    repeat (200) @(negedge clk);
    ifA.pulsein = 1'b0;
    n = 0;
    while (!ifA.done && n < 20) begin n++; @(negedge clk); end
    chk("p1_done_seen", 32'(ifA.done), 1);
    chk("p1_done_id",   32'(ifA.done_id), 1);
    chk("p1_echo",      32'(ifA.echo_us), 100);
    chk("p1_timeout",   32'(ifA.timeout), 0);
    chk("p1_grant_off", 32'(ifA.grant), 0);
    @(negedge clk);
    chk("p1_done_1cyc", 32'(ifA.done), 0);
    chk("p1_echo_hold", 32'(ifA.echo_us), 100);
    n = 0;
    while (ifA.busy && n < 1000) begin n++; @(negedge clk); end
    chk("p1_idle", 32'(ifA.busy), 0);

    // round robin over 5 pings on B (echo never rises -> timeouts)
    ifB.req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      n = 0;
      while (ifB.grant == 0 && n < 3000) begin n++; @(negedge clk); end
      chk("rr_grant", 32'(ifB.grant), 32'(1) << (p % 4));
      if (p == 4) ifB.req = '0;
      if (p == 0) begin
        n = 0;
        while (ifB.pulseen && n < 3000) begin n++; @(negedge clk); end
        n = 0;
        while (!ifB.done && n < 300) begin n++; @(negedge clk); end
        chk("to_done_lat", 32'(n), 100);
      end else begin
        n = 0;
        while (!ifB.done && n < 3000) begin n++; @(negedge clk); end
      end
      chk("rr_done",    32'(ifB.done), 1);
      chk("rr_done_id", 32'(ifB.done_id), 32'(p % 4));
      chk("rr_timeout", 32'(ifB.timeout), 1);
      chk("rr_echo",    32'(ifB.echo_us), 0);
      @(negedge clk);
    end
    n = 0;
    while (ifB.busy && n < 1000) begin n++; @(negedge clk); end
    chk("rr_idle", 32'(ifB.busy), 0);

    // stuck-high echo on B
    ifB.pulsein = 1'b1;
    ifB.req = 4'b0001;
    @(negedge clk);
    chk("st_grant", 32'(ifB.grant), 32'b0001);
    ifB.req = '0;
    n = 0;
    while (!ifB.done && n < 3000) begin n++; @(negedge clk); end
    chk("st_done",    32'(ifB.done), 1);
    chk("st_timeout", 32'(ifB.timeout), 1);
    chk("st_echo",    32'(ifB.echo_us), 50);
    repeat (1000) @(negedge clk);
    chk("st_delay_held", 32'(ifB.busy), 1);
    ifB.pulsein = 1'b0;
    n = 0;
    while (ifB.busy && n < 10) begin n++; @(negedge clk); end
    chk("st_idle", 32'(ifB.busy), 0);

    // reset mid-MEASURE on A
    ifA.req = 4'b0001;
    @(negedge clk);
    chk("rm_grant", 32'(ifA.grant), 32'b0001);
    ifA.req = '0;
    n = 0;
    while (ifA.pulseen && n < 3000) begin n++; @(negedge clk); end
    ifA.pulsein = 1'b1;
    repeat (30) @(negedge clk);
    chk("rm_in_measure", 32'(ifA.grant), 32'b0001);
    reset = 1'b1;
    @(negedge clk);
    chk("rm_grant0",   32'(ifA.grant), 0);
    chk("rm_busy0",    32'(ifA.busy), 0);
    chk("rm_done0",    32'(ifA.done), 0);
    chk("rm_pulseen",  32'(ifA.pulseen), 1);
    reset = 1'b0;
    ifA.pulsein = 1'b0;
    dn = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifA.done) dn++;
    end
    chk("rm_no_done", 32'(dn), 0);
    chk("rm_idle",    32'(ifA.busy), 0);
    ifA.req = 4'b1111;
    @(negedge clk);
    chk("rm_ptr0", 32'(ifA.grant), 32'b0001);
    ifA.req = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ping_sched.md
# ping_sched

Shared-sensor scheduler for the PING ultrasonic ranger. It arbitrates up to NREQ requesters for one sensor pin and sequences the full ping cycle: start pulse, hold-off, echo wait, echo measurement and re-arm delay. It generates every phase timer internally from a microsecond prescaler and returns the echo width in microseconds to the granted requester. It sits between the sensor pin logic (pulseout/pulseen/pulsein) and the range-consumer blocks.

## Interface
- CLK_MHZ, 50: clock cycles per microsecond.
- NREQ, 4: number of requesters, 1..8.
- W, 16: echo_us width.
- T_START_US, 5: start pulse length.
- T_HOLD_US, 750: hold-off before echo wait.
- T_ECHO_MAX_US, 18500: echo wait/measure timeout.
- T_DELAY_US, 200: re-arm delay.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  level request per requester.
- grant  out  NREQ  one-hot owner of the current ping; all-zero when idle.
- pulsein  in  1  echo line from the sensor pin.
- pulseout  out  1  start pulse drive value.
- pulseen  out  1  pin output enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle result strobe.
- done_id  out  $clog2(NREQ)  index of the requester the result belongs to.
- echo_us  out  W  measured width, held until the next done.
- timeout  out  1  qualifies echo_us; held with it.

## Operation
- States: IDLE, START, HOLD, WAIT_RISE, MEASURE, DELAY.
- Reset forces IDLE and clears the prescaler, the us counter and the arbiter pointer to 0. Reset values: grant=0, pulseout=0, pulseen=1, busy=0, done=0, done_id=0, echo_us=0, timeout=0.
- IDLE: if any req is high, the round-robin grant goes to the first requester at or after the pointer. The pointer then becomes granted+1, modulo NREQ. Next state is START.
- START: pulseout=1, pulseen=1. Exits to HOLD when the us counter reaches T_START_US.
- HOLD: pulseout=0, pulseen=1. Exits to WAIT_RISE when the us counter reaches T_HOLD_US.
- WAIT_RISE: pulseen=0.
  - Synchronized pulsein high goes to MEASURE.
  - If the us counter reaches T_ECHO_MAX_US first: done, timeout=1, echo_us=0, then DELAY.
- MEASURE: the us counter counts echo-high time.
  - Synchronized pulsein low: done, timeout=0, echo_us=count, then DELAY.
  - If the count reaches T_ECHO_MAX_US: done, timeout=1, echo_us=T_ECHO_MAX_US, then DELAY.
- DELAY: grant=0. Exits to IDLE when the us counter is ≥ T_DELAY_US and synchronized pulsein is low. A stuck echo therefore extends DELAY.
- The prescaler and us counter clear on every state entry. The us counter saturates at 2^W−1.
- The grant is held from START until the done cycle. Dropping req mid-ping does not abort the ping.
- Requests arriving outside IDLE wait for the next IDLE.

## Timing
- IDLE to START is 1 cycle after req is sampled high; grant asserts on the same edge.
- START lasts exactly T_START_US·CLK_MHZ cycles; HOLD lasts exactly T_HOLD_US·CLK_MHZ cycles.
- echo_us = floor(synchronized high cycles / CLK_MHZ).
- done is registered and asserts the cycle after the terminating condition is seen.
- done, done_id, echo_us and timeout update on the same edge.
- Synchronizer latency is 2 cycles; both edges are delayed equally, so the width is unaffected.
- Reset has priority over all transitions, including a reset asserted mid-ping; no done is issued.

## Configuration
- PING_SCHED_SYNC_EN defined: pulsein passes through a 2-flop synchronizer before use.
- PING_SCHED_SYNC_EN undefined: pulsein is used directly, with 0-cycle latency. Use this only when the pin block already synchronizes.

## Structure
- Package ping_pkg holds:
  - the state enum ping_state_t;
  - default timing constants (PING_T_START_US, PING_T_HOLD_US, PING_T_DELAY_US, PING_T_ECHO_MAX_US);
  - the PING_CLK_MHZ default.
- Sub-module ping_rr_arb: a NREQ-wide round-robin arbiter with an advance strobe, producing the one-hot grant and the index.

## Test plan
All scenarios use CLK_MHZ=2 unless stated.
- Reset held 2 cycles: pulseout=0, pulseen=1, grant=0, busy=0, done=0, echo_us=0.
- req=0010, echo high 200 cycles after HOLD ends:
  - grant=0010 one cycle later;
  - pulseout high exactly 10 cycles, then pulseen falls 1500 cycles later;
  - done=1 with done_id=1, echo_us=100, timeout=0.
- req=1111 held for 5 pings: grant sequence 0001, 0010, 0100, 1000, 0001.
- pulsein never rises, T_ECHO_MAX_US=50: done 100 cycles after WAIT_RISE entry, timeout=1, echo_us=0.
- pulsein stuck high, T_ECHO_MAX_US=50: done with timeout=1, echo_us=50. DELAY holds until pulsein falls, then IDLE.
- reset asserted mid-MEASURE: next cycle IDLE, grant=0, busy=0, no done pulse, pointer=0.
